// File: rtl/per2axi_req_sequencer.sv
// per2axi_req_sequencer: registered peripheral-to-AXI4 request sequencer with outstanding-transaction limit.
// Optional PER2AXI_SEQ_BACK2BACK_EN: grant in the completing cycle for back-to-back requests.
module per2axi_req_sequencer #(
   parameter int PER_ADDR_WIDTH  = 32,
   parameter int PER_ID_WIDTH    = 5,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int AXI_ID_WIDTH    = 3,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
)(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          per_slave_req_i,
   input  logic [PER_ADDR_WIDTH-1:0]     per_slave_add_i,
   input  logic                          per_slave_we_i,
   input  logic [31:0]                   per_slave_wdata_i,
   input  logic [3:0]                    per_slave_be_i,
   input  logic [PER_ID_WIDTH-1:0]       per_slave_id_i,
   output logic                          per_slave_gnt_o,
   output logic                          axi_master_aw_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0]     axi_master_aw_addr_o,
   output logic [AXI_ID_WIDTH-1:0]       axi_master_aw_id_o,
   output logic [2:0]                    axi_master_aw_size_o,
   input  logic                          axi_master_aw_ready_i,
   output logic                          axi_master_w_valid_o,
   output logic [AXI_DATA_WIDTH-1:0]     axi_master_w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   axi_master_w_strb_o,
   output logic                          axi_master_w_last_o,
   input  logic                          axi_master_w_ready_i,
   output logic                          axi_master_ar_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0]     axi_master_ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]       axi_master_ar_id_o,
   output logic [2:0]                    axi_master_ar_size_o,
   input  logic                          axi_master_ar_ready_i,
   input  logic                          b_done_i,
   input  logic                          r_done_i,
   output logic [CNT_W-1:0]              outstanding_o,
   output logic                          busy_o
);
   localparam int SW = AXI_DATA_WIDTH / 8;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t                    r_state;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [SW-1:0]             r_strb;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [2:0]                r_size;
   logic                      r_aw_valid, r_w_valid, r_ar_valid;
   logic [CNT_W-1:0]          r_cnt;

   logic             w_aw_hs, w_ar_hs, w_fin, w_gnt, w_cap, w_under;
   logic [1:0]       w_inc, w_dec;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Highest set bit of the one-hot ID wins; an all-zero ID maps to 0.
   function automatic logic [AXI_ID_WIDTH-1:0] f_id(input logic [PER_ID_WIDTH-1:0] id);
      f_id = '0;
      for (int i = 0; i < PER_ID_WIDTH; i++)
         if (id[i]) f_id = AXI_ID_WIDTH'(i);
   endfunction

   function automatic logic [2:0] f_size(input logic [3:0] be);
      return (be inside {4'b1100, 4'b0011}) ? 3'd1 :
             (be inside {4'b1111, 4'b0110, 4'b1110, 4'b0111}) ? 3'd2 : 3'd0;
   endfunction

   assign w_aw_hs   = r_aw_valid & axi_master_aw_ready_i;
   assign w_ar_hs   = r_ar_valid & axi_master_ar_ready_i;
   assign w_inc     = {1'b0, w_aw_hs} + {1'b0, w_ar_hs};
   assign w_dec     = {1'b0, b_done_i} + {1'b0, r_done_i};
   assign w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);
   assign w_under   = w_sum < (CNT_W+1)'(w_dec);
   assign w_cnt_nxt = w_under ? '0 : CNT_W'(w_sum - (CNT_W+1)'(w_dec));

   // Last pending handshake of the current transaction completes this cycle.
   assign w_fin = ((r_state == S_WRITE) & (~r_aw_valid | axi_master_aw_ready_i) &
                   (~r_w_valid | axi_master_w_ready_i)) |
                  ((r_state == S_READ) & axi_master_ar_ready_i);

`ifdef PER2AXI_SEQ_BACK2BACK_EN
   assign w_gnt = rst_ni & (((r_state == S_IDLE) & (r_cnt < MAX_C)) | (w_fin & (w_cnt_nxt < MAX_C)));
`else
   assign w_gnt = rst_ni & (r_state == S_IDLE) & (r_cnt < MAX_C);
`endif

   assign w_cap = per_slave_req_i & w_gnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_data     <= '0;
         r_strb     <= '0;
         r_id       <= '0;
         r_size     <= '0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
         r_ar_valid <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_cap) begin
            r_state    <= per_slave_we_i ? S_READ : S_WRITE;
            r_aw_valid <= ~per_slave_we_i;
            r_w_valid  <= ~per_slave_we_i;
            r_ar_valid <= per_slave_we_i;
            r_addr     <= AXI_ADDR_WIDTH'(per_slave_add_i);
            r_data     <= AXI_DATA_WIDTH'(per_slave_wdata_i) << {per_slave_add_i[2], 5'b0};
            r_strb     <= SW'(per_slave_be_i) << {per_slave_add_i[2], 2'b0};
            r_id       <= f_id(per_slave_id_i);
            r_size     <= f_size(per_slave_be_i);
         end else if (w_fin) begin
            r_state    <= S_IDLE;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
         end else begin
            r_aw_valid <= r_aw_valid & ~axi_master_aw_ready_i;
            r_w_valid  <= r_w_valid & ~axi_master_w_ready_i;
            r_ar_valid <= r_ar_valid & ~axi_master_ar_ready_i;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i)
      if (rst_ni) assert (!w_under) else $error("outstanding counter underflow");
`endif

   assign per_slave_gnt_o       = w_gnt;
   assign axi_master_aw_valid_o = r_aw_valid;
   assign axi_master_aw_addr_o  = r_addr;
   assign axi_master_aw_id_o    = r_id;
   assign axi_master_aw_size_o  = r_size;
   assign axi_master_w_valid_o  = r_w_valid;
   assign axi_master_w_data_o   = r_data;
   assign axi_master_w_strb_o   = r_strb;
   assign axi_master_w_last_o   = r_w_valid;
   assign axi_master_ar_valid_o = r_ar_valid;
   assign axi_master_ar_addr_o  = r_addr;
   assign axi_master_ar_id_o    = r_id;
   assign axi_master_ar_size_o  = r_size;
   assign outstanding_o         = r_cnt;
   assign busy_o                = r_state != S_IDLE;
endmodule
